seq_divider: RTL and testbench

Sequential unsigned restoring divider: the inverse-direction companion to the team's adder-based multiplier datapath. Accepts a dividend/divisor pair on a start pulse and computes one quotient bit per clock, using a WIDTH+1-bit subtract/restore step. Quotient and remainder are held stable after completion until the next accepted start. Sits beside the multiplier as the arithmetic unit's divide path.

---
 rtl/seq_divider_if.sv | 38 +++
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The master issues operands; the slave (divider) returns results.
interface seq_divider_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results are registered and held until the next accepted start.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // One restoring step: shift {R,Q}, trial-subtract at WIDTH+1 bits.
  // The shifted remainder can exceed WIDTH bits before the subtract,
  // so the extra bit is kept until the sign of the trial is known.
  always_comb begin
    shifted = {rem_w, quo_w[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    fits    = ~trial[WIDTH];
    rem_nx  = fits ? trial[WIDTH-1:0]
                   : shifted[WIDTH-1:0];
    quo_nx  = {quo_w[WIDTH-2:0], fits};
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      rem_w  <= '0;
      quo_w  <= '0;
      dvsr   <= '0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dvsr  <= bus.divisor;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            if (bus.divisor == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              quo_q  <= '1;
              rem_q  <= bus.dividend;
              dbz_q  <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
              rem_w  <= '0;
              quo_w  <= bus.dividend;
              cnt    <= CW'(WIDTH);
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          rem_w <= rem_nx;
          quo_w <= quo_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            quo_q  <= quo_nx;
            rem_q  <= rem_nx;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8).
// Expected results are queued at issue and popped on done.
module tb_seq_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Issue one op and wait (bounded) for done; lat=1 is the cycle
  // after the accepting edge.
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output int lat, output int nbusy);
    exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000",
               {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++;
    if ({bus.quotient, bus.remainder} !== 16'h0) begin
      failures++;
      $display("FAIL reset_results got q=%0d r=%0d want 0 0",
               bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_basic();
    int lat, nb;
    exp_t e;
    run_op(8'd100, 8'd7, lat, nb);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=9", lat);
    end
    checks++;
    if (nb !== 8) begin
      failures++;
      $display("FAIL basic_busy got=%0d want=8", nb);
    end
    checks++;
    if (bus.quotient !== e.q || bus.remainder !== e.r
        || bus.div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got %0d r %0d dz %b want %0d r %0d dz 0",
               bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.quotient !== 8'd14
        || bus.remainder !== 8'd2) begin
      failures++;
      $display("FAIL basic_hold got done=%b q=%0d r=%0d want 0 14 2",
               bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] ta [3] = '{8'd255, 8'd3, 8'd255};
    logic [W-1:0] tb [3] = '{8'd1, 8'd10, 8'd255};
    logic [W-1:0] tq [3] = '{8'd255, 8'd0, 8'd1};
    logic [W-1:0] tr [3] = '{8'd0, 8'd3, 8'd0};
    int lat, nb;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], lat, nb);
      e = exp_q.pop_front();
      checks++;
      if (lat !== 9 || bus.quotient !== tq[i]
          || bus.remainder !== tr[i] || e.q !== tq[i]) begin
        failures++;
        $display("FAIL edge_%0d got lat=%0d q=%0d r=%0d want 9 %0d %0d",
                 i, lat, bus.quotient, bus.remainder, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, nb;
    exp_t e;
    run_op(8'd5, 8'd0, lat, nb);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 1 || nb !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL dz_timing got lat=%0d busy_cycles=%0d want 1 0",
               lat, nb);
    end
    checks++;
    if (bus.quotient !== e.q || bus.remainder !== e.r
        || bus.div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_result got %0d r %0d dz %b want 255 r 5 dz 1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_hold got done=%b dz=%b want 0 1",
               bus.done, bus.div_by_zero);
    end
  endtask

  task automatic test_start_during_run();
    int lat;
    exp_t e;
    exp_q.push_back(model(8'd100, 8'd7));
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 8'd7;
    @(negedge clk);
    bus.dividend = 8'd33;
    bus.divisor = 8'd3;
    lat = 1;
    while (!bus.done && lat < 30) begin
      if (lat == 5) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (lat !== 9 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      failures++;
      $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want 9 14 2",
               lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    exp_t e;
    run_op(8'd100, 8'd7, lat, nb);
    e = exp_q.pop_front();
    exp_q.push_back(model(8'd200, 8'd9));
    bus.start = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept got done=%b busy=%b want 0 1",
               bus.done, bus.busy);
    end
    lat = 1;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    checks++;
    if (lat !== 9 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      failures++;
      $display("FAIL b2b_result got lat=%0d q=%0d r=%0d want 9 22 2",
               lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, nb, seen;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.quotient !== 8'd0
        || bus.remainder !== 8'd0) begin
      failures++;
      $display("FAIL midrst_state got busy=%b done=%b q=%0d r=%0d want 0",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midrst_nodone got=%0d want=0", seen);
    end
    run_op(8'd50, 8'd6, lat, nb);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 9 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      failures++;
      $display("FAIL midrst_after got lat=%0d q=%0d r=%0d want 9 8 2",
               lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int lat, nb;
    exp_t e;
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      run_op(a, b, lat, nb);
      e = exp_q.pop_front();
      checks++;
      if (lat !== 9 || bus.quotient !== e.q || bus.remainder !== e.r
          || 16'(bus.quotient) * 16'(b) + 16'(bus.remainder) !== 16'(a)
          || !(bus.remainder < b)) begin
        failures++;
        $display("FAIL rand_%0d %0d/%0d got lat=%0d q=%0d r=%0d want %0d r %0d",
                 i, a, b, lat, bus.quotient, bus.remainder, e.q, e.r);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
